// File: rtl/game_pkg.sv
// Shared definitions for the jump game player path.
//   - motion_state_t : player motion state encoding (IDLE..FALL)
//   - hdir_t         : airborne horizontal direction, two's-complement -1/0/+1
//   - geometry and physics constants, in both unsigned 10-bit form (for
//     registers) and signed 11-bit form (for pre-clamp arithmetic)
//   - clamp_x / out_of_x : horizontal range helpers
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK   = 3'd1,
        ST_CHARGE = 3'd2,
        ST_RISE   = 3'd3,
        ST_FALL   = 3'd4
    } motion_state_t;

    // Encoded as a 2-bit two's-complement step direction.
    typedef enum logic [1:0] {
        HDIR_NONE  = 2'b00,
        HDIR_RIGHT = 2'b01,
        HDIR_LEFT  = 2'b11
    } hdir_t;

    localparam int SCREEN_W = 640;
    localparam int PLAYER_W = 16;
    localparam int PLAYER_H = 16;
    localparam int GROUND_Y = 448;

    localparam logic [9:0] X_INIT     = 10'd312;
    localparam logic [9:0] X_MAX      = 10'(SCREEN_W - PLAYER_W);  // 624
    localparam logic [9:0] GROUND_TOP = 10'(GROUND_Y - PLAYER_H);  // 432
    localparam logic [4:0] CHARGE_MAX = 5'd31;
    localparam logic [5:0] GRAVITY    = 6'd1;
    localparam logic [5:0] VY_MAX     = 6'd16;

    localparam logic signed [10:0] WALK_STEP_S  = 11'sd2;
    localparam logic signed [10:0] X_MAX_S      = 11'sd624;
    localparam logic signed [10:0] GROUND_TOP_S = 11'sd432;

    function automatic logic out_of_x(input logic signed [10:0] v);
        return (v < 11'sd0) || (v > X_MAX_S);
    endfunction

    function automatic logic [9:0] clamp_x(input logic signed [10:0] v);
        if (v < 11'sd0) begin
            return 10'd0;
        end else if (v > X_MAX_S) begin
            return X_MAX;
        end
        return v[9:0];
    endfunction

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Player control bundle between the input/frame logic and the motion
// sequencer, and from the sequencer to the sprite renderer.
//   inputs  : left_btn, right_btn, jump_btn (debounced levels), frame_tick
//   outputs : pos_x, pos_y, facing, state, charge, on_ground
// There is no handshake: buttons are levels and frame_tick is a single
// cycle qualifier; the outputs are registered and hold between ticks.
// master = side driving buttons/tick and consuming position,
// slave  = the motion sequencer.
interface player_motion_ctrl_if;
    logic       left_btn;
    logic       right_btn;
    logic       jump_btn;
    logic       frame_tick;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       facing;
    logic [2:0] state;
    logic [4:0] charge;
    logic       on_ground;

    modport master (
        output left_btn, right_btn, jump_btn, frame_tick,
        input  pos_x, pos_y, facing, state, charge, on_ground
    );

    modport slave (
        input  left_btn, right_btn, jump_btn, frame_tick,
        output pos_x, pos_y, facing, state, charge, on_ground
    );
endinterface

// File: rtl/player_motion_ctrl_frame_tick_gen.sv
// frame_tick_gen: turns the VGA vsync level into a one-cycle frame_tick
// pulse on each vsync falling edge.
//   clk, rst_n  : clock, asynchronous active-low reset
//   vsync       : vsync level from the sync generator
//   frame_tick  : registered one-cycle pulse, one cycle after the edge
// The previous-sample register resets to 0, so a vsync that is already low
// when reset releases does not look like an edge.
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic frame_tick
);
    logic vsync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            frame_tick <= vsync_d & ~vsync;
        end
    end
endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame player movement sequencer.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : buttons + frame_tick in; pos_x, pos_y, facing,
//                        state, charge, on_ground out (all registered)
// Everything advances only on frame_tick cycles. The FSM state is visible
// directly on bus.state for debug and rendering.
module player_motion_ctrl
    import game_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    player_motion_ctrl_if.slave   bus
);
    motion_state_t state_q;
    hdir_t         hdir_q;
    logic [9:0]    pos_x_q;
    logic [9:0]    pos_y_q;
    logic          facing_q;
    logic [4:0]    charge_q;
    logic [5:0]    vy_q;
    logic          on_ground_q;

    logic                 one_dir;
    logic signed [10:0]   x_s;
    logic signed [10:0]   y_s;
    logic signed [10:0]   vy_s;
    logic signed [10:0]   walk_x_raw;
    logic signed [10:0]   air_x_raw;
    logic signed [10:0]   rise_y_raw;
    logic signed [10:0]   fall_y_raw;
    logic [9:0]           walk_x;
    logic [9:0]           air_x;
    logic                 air_bounce;
    hdir_t                hdir_flip;
    hdir_t                hdir_release;
    logic [5:0]           vy_fall_next;

    // Pre-clamp arithmetic is done in 11-bit signed so stepping past either
    // edge (or above row 0) is seen as out of range rather than wrapping.
    always_comb begin
        one_dir    = bus.left_btn ^ bus.right_btn;
        x_s        = signed'({1'b0, pos_x_q});
        y_s        = signed'({1'b0, pos_y_q});
        vy_s       = signed'({5'b0, vy_q});
        walk_x_raw = bus.right_btn ? (x_s + WALK_STEP_S) : (x_s - WALK_STEP_S);
        walk_x     = clamp_x(walk_x_raw);

        air_x_raw = x_s;
        hdir_flip = HDIR_NONE;
        case (hdir_q)
            HDIR_RIGHT: begin
                air_x_raw = x_s + WALK_STEP_S;
                hdir_flip = HDIR_LEFT;
            end
            HDIR_LEFT: begin
                air_x_raw = x_s - WALK_STEP_S;
                hdir_flip = HDIR_RIGHT;
            end
            default: begin
                air_x_raw = x_s;
                hdir_flip = HDIR_NONE;
            end
        endcase
        air_x      = clamp_x(air_x_raw);
        air_bounce = out_of_x(air_x_raw);

        hdir_release = HDIR_NONE;
        if (one_dir) begin
            hdir_release = bus.right_btn ? HDIR_RIGHT : HDIR_LEFT;
        end

        rise_y_raw   = y_s - vy_s;
        fall_y_raw   = y_s + vy_s;
        vy_fall_next = ((vy_q + GRAVITY) > VY_MAX) ? VY_MAX : (vy_q + GRAVITY);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            hdir_q      <= HDIR_NONE;
            pos_x_q     <= X_INIT;
            pos_y_q     <= GROUND_TOP;
            facing_q    <= 1'b1;
            charge_q    <= 5'd0;
            vy_q        <= 6'd0;
            on_ground_q <= 1'b1;
        end else if (bus.frame_tick) begin
            case (state_q)
                ST_IDLE, ST_WALK: begin
                    on_ground_q <= 1'b1;
                    if (bus.jump_btn) begin
                        // Jump wins over walking; x stays put this frame.
                        state_q  <= ST_CHARGE;
                        charge_q <= 5'd0;
                    end else if (one_dir) begin
                        state_q  <= ST_WALK;
                        pos_x_q  <= walk_x;
                        facing_q <= bus.right_btn;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_CHARGE: begin
                    if (one_dir) begin
                        facing_q <= bus.right_btn;
                    end
                    if (bus.jump_btn) begin
                        if (charge_q != CHARGE_MAX) begin
                            charge_q <= charge_q + 5'd1;
                        end
                    end else begin
                        state_q     <= ST_RISE;
                        on_ground_q <= 1'b0;
                        vy_q        <= {1'b0, charge_q} + 6'd1;
                        charge_q    <= 5'd0;
                        hdir_q      <= hdir_release;
                    end
                end

                ST_RISE, ST_FALL: begin
                    pos_x_q <= air_x;
                    if (air_bounce) begin
                        hdir_q   <= hdir_flip;
                        facing_q <= (hdir_flip == HDIR_RIGHT);
                    end
                    if (state_q == ST_RISE) begin
                        if (rise_y_raw <= 11'sd0) begin
                            // Hit the top of the screen: stop rising at once.
                            pos_y_q <= 10'd0;
                            vy_q    <= 6'd0;
                            state_q <= ST_FALL;
                        end else begin
                            pos_y_q <= rise_y_raw[9:0];
                            if (vy_q <= GRAVITY) begin
                                vy_q    <= 6'd0;
                                state_q <= ST_FALL;
                            end else begin
                                vy_q <= vy_q - GRAVITY;
                            end
                        end
                    end else begin
                        if (fall_y_raw >= GROUND_TOP_S) begin
                            // Landing overrides any bounce on the same frame.
                            pos_y_q     <= GROUND_TOP;
                            state_q     <= ST_IDLE;
                            on_ground_q <= 1'b1;
                            vy_q        <= 6'd0;
                            hdir_q      <= HDIR_NONE;
                        end else begin
                            pos_y_q <= fall_y_raw[9:0];
                            vy_q    <= vy_fall_next;
                        end
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    on_ground_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.facing    = facing_q;
    assign bus.state     = state_q;
    assign bus.charge    = charge_q;
    assign bus.on_ground = on_ground_q;

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Per-frame player movement sequencer for the jump game.
- Turns the debounced left/right/jump buttons into player position, facing and motion state.
- Walk, charge-jump, rise and fall phases are advanced once per video frame.
- Outputs feed the sprite/render path that drives rgb alongside the VGA sync generator.

Parameters:
- SCREEN_W, 640, visible width in pixels
- PLAYER_W, 16, sprite width
- PLAYER_H, 16, sprite height
- GROUND_Y, 448, ground surface row; player top at rest = GROUND_Y-PLAYER_H (GROUND_TOP = 432)
- X_INIT, 312, reset x
- WALK_STEP, 2, horizontal pixels per frame
- CHARGE_MAX, 31, charge saturation value
- GRAVITY, 1, vy change per frame
- VY_MAX, 16, terminal fall speed

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- left_btn  in  1  level, synchronised and debounced upstream
- right_btn  in  1  level, synchronised and debounced upstream
- jump_btn  in  1  level, synchronised and debounced upstream
- frame_tick  in  1  one-cycle pulse per frame (vsync edge)
- pos_x  out  10  player left column
- pos_y  out  10  player top row
- facing  out  1  1=right, 0=left
- state  out  3  motion state, game_pkg encoding
- charge  out  5  current jump charge
- on_ground  out  1  high in IDLE, WALK and CHARGE

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous, active-low on sys_rst_n.
- Reset values: pos_x=X_INIT, pos_y=GROUND_TOP, facing=1, state=IDLE, charge=0, internal vy=0, hdir=0, on_ground=1.
- Reset mid-operation (including airborne) returns all of the above immediately.
- All state and register updates occur only on cycles with frame_tick=1; otherwise everything holds.
- All outputs are registered; an update is visible the cycle after the tick.
- Buttons are sampled on the tick cycle only.
- IDLE / WALK:
  - jump_btn=1 -> CHARGE, charge=0, no x move. Jump has priority over walk.
  - Else left XOR right -> WALK; x moves WALK_STEP toward the pressed side; facing updated.
  - x saturates to the range [0, SCREEN_W-PLAYER_W=624].
  - Both buttons or neither -> IDLE, x unchanged.
- CHARGE:
  - jump_btn=1 -> charge+1, saturating at CHARGE_MAX; left/right update facing only.
  - jump_btn=0 -> RISE, vy=charge+1 (6-bit), charge=0.
  - hdir latched at release: -1 if left only, +1 if right only, else 0.
- RISE, each tick:
  - y = y-vy, saturating at 0; hitting 0 forces vy=0 and transitions to FALL.
  - If vy <= GRAVITY -> FALL with vy=0.
  - Else vy = vy-GRAVITY.
- FALL, each tick:
  - If y+vy >= GROUND_TOP -> y=GROUND_TOP, state=IDLE, vy=0, hdir=0.
  - Else y = y+vy and vy = min(vy+GRAVITY, VY_MAX).
- Airborne horizontal motion (RISE/FALL):
  - x += hdir*WALK_STEP.
  - If the result leaves [0, 624], x clamps to the bound and hdir (and facing) inverts (wall bounce).
  - Buttons are ignored while airborne.
- Arithmetic: internal next-x and next-y use 11-bit signed math before clamping. No wrap-around is permitted.

Decomposition:
- game_pkg holds:
  - state encoding: IDLE=0, WALK=1, CHARGE=2, RISE=3, FALL=4
  - screen and player geometry constants
  - hdir encoding
- One natural sub-module, frame_tick_gen: converts vsync into the frame_tick pulse.
  - Falling-edge detector, reset to 0, no pulse on the first cycle after reset.

Test Plan:
- Reset, then 3 ticks with no buttons -> pos=(312,432), state=IDLE, facing=1, charge=0, on_ground=1.
- right_btn held for 5 ticks -> pos_x=322, state=WALK; release then 1 tick -> IDLE, x=322. left_btn from x=2 for 3 ticks -> x=0, facing=0.
- jump_btn held 3 ticks, release with no direction:
  - charge reaches 3, then vy=4.
  - y per tick: 428, 425, 423, 422 (FALL), 422, 423, 425, 428, 432 -> IDLE.
  - x unchanged throughout.
- Start x=620, charge 3, release with right_btn held:
  - x per tick: 622, 624, 624 (bounce, facing=0), 622, ...
  - Lands at 432 with state IDLE.
- jump_btn held 40 ticks -> charge=31. Release, then assert sys_rst_n=0 two ticks into RISE -> outputs at reset values with no clock edge needed.
- Toggle every button with no frame_tick for 1000 cycles -> all outputs constant.
